// File: rtl/apb_arb_mux.sv
// N:1 APB requester mux: arbitrates masters holding PSEL, replays the winner's
// request on a single slave port and returns the completion to that master only.
//
// state  | meaning
// IDLE   | no transfer; arbitration runs every cycle
// SETUP  | PSEL_m high, PENABLE_m low, winner's request registered
// ACCESS | PSEL_m and PENABLE_m high; waits for PREADY_m or watchdog expiry
module apb_arb_mux #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int IDW           = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                                    PCLK,
    input  logic                                    PRESETn,
    input  logic [NUM_MASTERS-1:0]                  PSEL_s,
    input  logic [NUM_MASTERS-1:0]                  PENABLE_s,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  PADDR_s,
    input  logic [NUM_MASTERS-1:0]                  PWRITE_s,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  PWDATA_s,
    input  logic [NUM_MASTERS-1:0][STRB_WIDTH-1:0]  PSTRB_s,
    input  logic [NUM_MASTERS-1:0][2:0]             PPROT_s,
    output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  PRDATA_s,
    output logic [NUM_MASTERS-1:0]                  PREADY_s,
    output logic [NUM_MASTERS-1:0]                  PSLVERR_s,
    output logic                                    PSEL_m,
    output logic                                    PENABLE_m,
    output logic                                    PWRITE_m,
    output logic [ADDR_WIDTH-1:0]                   PADDR_m,
    output logic [DATA_WIDTH-1:0]                   PWDATA_m,
    output logic [STRB_WIDTH-1:0]                   PSTRB_m,
    output logic [2:0]                              PPROT_m,
    input  logic [DATA_WIDTH-1:0]                   PRDATA_m,
    input  logic                                    PREADY_m,
    input  logic                                    PSLVERR_m,
    output logic [IDW-1:0]                          grant_id,
    output logic                                    busy,
    output logic                                    timeout_pulse
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    state_t                 state_q, state_d;
    logic [IDW-1:0]         ptr_q, grant_q, win_idx, cand;
    logic                   win_vld;
    logic [CNT_W-1:0]       wd_cnt_q;
    logic                   wd_expire;
    logic [ADDR_WIDTH-1:0]  paddr_q;
    logic [DATA_WIDTH-1:0]  pwdata_q;
    logic [STRB_WIDTH-1:0]  pstrb_q;
    logic [2:0]             pprot_q;
    logic                   pwrite_q;

    // PENABLE_s carries no information for arbitration
    logic unused_penable;
    assign unused_penable = ^PENABLE_s;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = (ARB_MODE == 1) ? IDW'(i) : IDW'((int'(ptr_q) + i) % NUM_MASTERS);
            if (!win_vld && PSEL_s[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign wd_expire = (TIMEOUT_CYCLES > 0) && (state_q == ST_ACCESS) &&
                       !PREADY_m && (wd_cnt_q == WD_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (win_vld) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (PREADY_m || wd_expire) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            wd_cnt_q <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pprot_q  <= '0;
            pwrite_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (win_vld) begin
                        grant_q  <= win_idx;
                        paddr_q  <= PADDR_s[win_idx];
                        pwdata_q <= PWDATA_s[win_idx];
                        pstrb_q  <= PSTRB_s[win_idx];
                        pprot_q  <= PPROT_s[win_idx];
                        pwrite_q <= PWRITE_s[win_idx];
                        if (ARB_MODE == 0)
                            ptr_q <= (win_idx == IDW'(NUM_MASTERS - 1)) ? '0 : win_idx + IDW'(1);
                    end
                end
                ST_SETUP:  wd_cnt_q <= '0;
                ST_ACCESS: begin
                    if ((TIMEOUT_CYCLES > 0) && !PREADY_m && !wd_expire)
                        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Only the current owner sees the slave response, and only during ACCESS
    always_comb begin
        PRDATA_s      = '0;
        PREADY_s      = '0;
        PSLVERR_s     = '0;
        timeout_pulse = 1'b0;
        if (state_q == ST_ACCESS) begin
            PRDATA_s[grant_q]  = PRDATA_m;
            PREADY_s[grant_q]  = PREADY_m;
            PSLVERR_s[grant_q] = PSLVERR_m;
            if (wd_expire) begin
                PRDATA_s[grant_q]  = '0;
                PREADY_s[grant_q]  = 1'b1;
                PSLVERR_s[grant_q] = 1'b1;
                timeout_pulse      = 1'b1;
            end
        end
    end

    assign PSEL_m    = (state_q != ST_IDLE);
    assign PENABLE_m = (state_q == ST_ACCESS);
    assign busy      = (state_q != ST_IDLE);
    assign grant_id  = grant_q;
    assign PADDR_m   = paddr_q;
    assign PWDATA_m  = pwdata_q;
    assign PSTRB_m   = pstrb_q;
    assign PPROT_m   = pprot_q;
    assign PWRITE_m  = pwrite_q;

endmodule

// File: tb/tb_apb_arb_mux.sv
// Bench for apb_arb_mux: a round-robin and a fixed-priority instance share stimulus
// and are checked each cycle against a transfer-phase model plus literal expectations.
module tb_apb_arb_mux;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst_n = 1'b0;
    logic [N-1:0]              psel, penable, pwrite;
    logic [N-1:0][AW-1:0]      paddr;
    logic [N-1:0][DW-1:0]      pwdata;
    logic [N-1:0][SW-1:0]      pstrb;
    logic [N-1:0][2:0]         pprot;
    logic [DW-1:0]             prdata_m;
    logic                      pready_m, pslverr_m;

    logic [N-1:0][DW-1:0]      o_prdata_s [2];
    logic [N-1:0]              o_pready_s [2];
    logic [N-1:0]              o_pslverr_s [2];
    logic                      o_psel_m [2];
    logic                      o_penable_m [2];
    logic                      o_pwrite_m [2];
    logic [AW-1:0]             o_paddr_m [2];
    logic [DW-1:0]             o_pwdata_m [2];
    logic [SW-1:0]             o_pstrb_m [2];
    logic [2:0]                o_pprot_m [2];
    logic [1:0]                o_grant [2];
    logic                      o_busy [2];
    logic                      o_pulse [2];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        apb_arb_mux #(
            .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW),
            .ARB_MODE(d), .TIMEOUT_CYCLES(TO)
        ) u_dut (
            .PCLK(clk), .PRESETn(rst_n),
            .PSEL_s(psel), .PENABLE_s(penable), .PADDR_s(paddr), .PWRITE_s(pwrite),
            .PWDATA_s(pwdata), .PSTRB_s(pstrb), .PPROT_s(pprot),
            .PRDATA_s(o_prdata_s[d]), .PREADY_s(o_pready_s[d]), .PSLVERR_s(o_pslverr_s[d]),
            .PSEL_m(o_psel_m[d]), .PENABLE_m(o_penable_m[d]), .PWRITE_m(o_pwrite_m[d]),
            .PADDR_m(o_paddr_m[d]), .PWDATA_m(o_pwdata_m[d]), .PSTRB_m(o_pstrb_m[d]),
            .PPROT_m(o_pprot_m[d]), .PRDATA_m(prdata_m), .PREADY_m(pready_m),
            .PSLVERR_m(pslverr_m), .grant_id(o_grant[d]), .busy(o_busy[d]),
            .timeout_pulse(o_pulse[d])
        );
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: ph = -1 idle, 0 setup, k>=1 means k-th ACCESS cycle of the transfer
    int          ph [2]  = '{-1, -1};
    int          own [2] = '{0, 0};
    int          ptr [2] = '{0, 0};
    logic [71:0] m_pay [2];

    function automatic int pick(input logic [N-1:0] r, input int p, input int fp);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (fp != 0) ? i : (p + i) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                ph[d] = -1; own[d] = 0; ptr[d] = 0; m_pay[d] = '0;
            end else if (ph[d] < 0) begin
                int w;
                w = pick(psel, ptr[d], d);
                if (w >= 0) begin
                    own[d]   = w;
                    m_pay[d] = {paddr[w], pwrite[w], pwdata[w], pstrb[w], pprot[w]};
                    if (d == 0) ptr[d] = (w + 1) % N;
                    ph[d] = 0;
                end
            end else if (ph[d] == 0) begin
                ph[d] = 1;
            end else if (pready_m || ph[d] == TO) begin
                ph[d] = -1;
            end else begin
                ph[d] = ph[d] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [N-1:0]         er, ee;
            logic [N-1:0][DW-1:0] ed;
            logic                 ep;
            string                pf;
            pf = (d == 0) ? "rr_" : "fp_";
            er = '0; ee = '0; ed = '0; ep = 1'b0;
            if (ph[d] >= 1) begin
                ed[own[d]] = prdata_m;
                er[own[d]] = pready_m;
                ee[own[d]] = pslverr_m;
                if (!pready_m && ph[d] == TO) begin
                    ed[own[d]] = '0; er[own[d]] = 1'b1; ee[own[d]] = 1'b1; ep = 1'b1;
                end
            end
            chk({pf, "ctl"},
                {o_psel_m[d], o_penable_m[d], o_busy[d], o_pulse[d], o_grant[d]},
                {ph[d] >= 0, ph[d] >= 1, ph[d] >= 0, ep, 2'(own[d])});
            chk({pf, "payload"},
                {o_paddr_m[d], o_pwrite_m[d], o_pwdata_m[d], o_pstrb_m[d], o_pprot_m[d]},
                m_pay[d]);
            chk({pf, "resp"}, {o_pready_s[d], o_pslverr_s[d], o_prdata_s[d]}, {er, ee, ed});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        psel = '0; pready_m = 1'b0; pslverr_m = 1'b0; prdata_m = '0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    int g_rr[$], g_fp[$], c_rr[$];
    int exp_g[5] = '{0, 1, 2, 3, 0};
    int exp_c[5] = '{1, 4, 7, 10, 13};
    int n3;

    initial begin
        psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0;
        pstrb = '0; pprot = '0; prdata_m = '0; pready_m = 1'b0; pslverr_m = 1'b0;
        tick(); #2;
        chk("rst_psel_m", o_psel_m[0], 0);
        chk("rst_busy", o_busy[0], 0);
        chk("rst_pready_s", o_pready_s[0], 0);
        chk("rst_grant", o_grant[0], 0);

        // single write from master 2; master corrupts PWDATA after the grant
        do_reset();
        psel = 4'b0100; paddr[2] = 32'h100; pwrite[2] = 1'b1;
        pwdata[2] = 32'hDEADBEEF; pstrb[2] = 4'hF; pprot[2] = 3'd2; pready_m = 1'b1;
        #2 chk("t1_c0_psel_m", o_psel_m[0], 0);
        tick(); pwdata[2] = 32'h0BAD0BAD; #2;
        chk("t1_c1_psel_m", o_psel_m[0], 1);
        chk("t1_c1_penable_m", o_penable_m[0], 0);
        chk("t1_c1_paddr_m", o_paddr_m[0], 32'h100);
        tick(); #2;
        chk("t1_c2_penable_m", o_penable_m[0], 1);
        chk("t1_c2_pready_s", o_pready_s[0], 4'b0100);
        chk("t1_c2_pwdata_m", o_pwdata_m[0], 32'hDEADBEEF);
        tick(); psel = '0; #2;
        chk("t1_c3_psel_m", o_psel_m[0], 0);

        // all four requesting, zero-wait slave
        do_reset();
        for (int i = 0; i < N; i++) paddr[i] = 32'h1000 * i;
        psel = 4'b1111; pready_m = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick(); #2;
            if (o_psel_m[0] && !o_penable_m[0]) begin
                g_rr.push_back(int'(o_grant[0]));
                c_rr.push_back(c);
            end
            if (o_psel_m[1] && !o_penable_m[1]) g_fp.push_back(int'(o_grant[1]));
        end
        chk("t2_rr_ngrants", g_rr.size(), 5);
        for (int i = 0; i < g_rr.size() && i < 5; i++) begin
            chk($sformatf("t2_rr_grant%0d", i), g_rr[i], exp_g[i]);
            chk($sformatf("t2_rr_setup_cycle%0d", i), c_rr[i], exp_c[i]);
        end
        foreach (g_fp[i]) chk($sformatf("t2_fp_grant%0d", i), g_fp[i], 0);
        tick(); psel = '0;

        // fixed priority: masters 1 and 3 held
        do_reset();
        g_fp.delete();
        psel = 4'b1010; pready_m = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick(); #2;
            if (o_psel_m[1] && !o_penable_m[1]) g_fp.push_back(int'(o_grant[1]));
        end
        chk("t3_fp_ngrants", g_fp.size(), 4);
        n3 = 0;
        foreach (g_fp[i]) begin
            chk($sformatf("t3_fp_grant%0d", i), g_fp[i], 1);
            if (g_fp[i] == 3) n3++;
        end
        chk("t3_fp_master3_grants", n3, 0);
        tick(); psel = '0;

        // read from master 0 with two wait states and an error response
        do_reset();
        psel = 4'b0001; pwrite[0] = 1'b0; paddr[0] = 32'h40;
        pready_m = 1'b0; prdata_m = 32'h12345678; pslverr_m = 1'b1;
        tick(); tick(); #2;
        chk("t4_c2_pready_s", o_pready_s[0], 4'b0000);
        tick(); #2;
        chk("t4_c3_pready_s", o_pready_s[0], 4'b0000);
        tick(); pready_m = 1'b1; #2;
        chk("t4_c4_pready_s", o_pready_s[0], 4'b0001);
        chk("t4_c4_pslverr_s", o_pslverr_s[0], 4'b0001);
        chk("t4_c4_prdata_s", o_prdata_s[0], {96'h0, 32'h12345678});
        tick(); psel = '0; pready_m = 1'b0; pslverr_m = 1'b0;

        // watchdog abort after 8 ACCESS cycles
        do_reset();
        psel = 4'b0010; pready_m = 1'b0; prdata_m = 32'hAAAA5555;
        for (int c = 1; c <= 8; c++) tick();
        #2;
        chk("t5_c8_pready_s", o_pready_s[0], 4'b0000);
        chk("t5_c8_pulse", o_pulse[0], 0);
        tick(); #2;
        chk("t5_c9_pready_s", o_pready_s[0], 4'b0010);
        chk("t5_c9_pslverr_s", o_pslverr_s[0], 4'b0010);
        chk("t5_c9_prdata_s", o_prdata_s[0], 128'h0);
        chk("t5_c9_pulse", o_pulse[0], 1);
        tick(); psel = '0; #2;
        chk("t5_c10_psel_m", o_psel_m[0], 0);
        chk("t5_c10_pulse", o_pulse[0], 0);

        // PREADY_m rises on the expiry cycle: normal completion wins
        tick(); psel = 4'b0010;
        for (int c = 1; c <= 8; c++) tick();
        tick(); pready_m = 1'b1; pslverr_m = 1'b0; #2;
        chk("t5b_c9_pready_s", o_pready_s[0], 4'b0010);
        chk("t5b_c9_pslverr_s", o_pslverr_s[0], 4'b0000);
        chk("t5b_c9_pulse", o_pulse[0], 0);
        tick(); psel = '0; pready_m = 1'b0; #2;
        chk("t5b_c10_psel_m", o_psel_m[0], 0);

        // reset during ACCESS, then pointer must restart at 0
        do_reset();
        psel = 4'b0100; pready_m = 1'b0;
        tick(); tick(); pready_m = 1'b1; #1;
        chk("t6_pre_pready_s", o_pready_s[0], 4'b0100);
        rst_n = 1'b0; #1;
        chk("t6_rst_psel_m", o_psel_m[0], 0);
        chk("t6_rst_penable_m", o_penable_m[0], 0);
        chk("t6_rst_busy", o_busy[0], 0);
        chk("t6_rst_pready_s", {o_pready_s[0], o_pready_s[1]}, 8'h00);
        psel = '0;
        tick(); tick(); rst_n = 1'b1; psel = 4'b1001;
        tick(); #2;
        chk("t6_first_grant", o_grant[0], 0);
        chk("t6_first_psel_m", o_psel_m[0], 1);
        tick(); psel = '0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/apb_arb_mux.md
# apb_arb_mux

Parametrised N:1 APB requester multiplexer placed between several APB masters and one shared APB slave port. It arbitrates among masters holding PSEL, using either round-robin or fixed-priority arbitration, and registers the winner's request. It then runs a protocol-correct SETUP/ACCESS sequence on the slave side and routes the completion back to the winning master only. A configurable ACCESS-phase watchdog aborts hung transfers with an error response.

## Interface
- NUM_MASTERS, 4, number of requesting masters (≥2)
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width
- STRB_WIDTH, DATA_WIDTH/8, PSTRB width
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (index 0 highest)
- TIMEOUT_CYCLES, 256, ACCESS cycles before abort; 0 disables watchdog
- IDW (localparam), max(1, $clog2(NUM_MASTERS)), grant index width
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- PSEL_s  in  [NUM_MASTERS]  master select
- PENABLE_s  in  [NUM_MASTERS]  master enable (ignored for arbitration)
- PADDR_s  in  [NUM_MASTERS] x ADDR_WIDTH  address
- PWRITE_s  in  [NUM_MASTERS]  direction
- PWDATA_s  in  [NUM_MASTERS] x DATA_WIDTH  write data
- PSTRB_s  in  [NUM_MASTERS] x STRB_WIDTH  byte strobes
- PPROT_s  in  [NUM_MASTERS] x 3  protection
- PRDATA_s  out  [NUM_MASTERS] x DATA_WIDTH  read data
- PREADY_s / PSLVERR_s  out  [NUM_MASTERS]  completion / error
- PSEL_m, PENABLE_m, PWRITE_m  out  1  slave control
- PADDR_m  out  ADDR_WIDTH; PWDATA_m  out  DATA_WIDTH; PSTRB_m  out  STRB_WIDTH; PPROT_m  out  3
- PRDATA_m  in  DATA_WIDTH; PREADY_m, PSLVERR_m  in  1  slave response
- grant_id  out  IDW  index of the current owner (valid while busy)
- busy  out  1  high in SETUP or ACCESS
- timeout_pulse  out  1  one-cycle pulse on watchdog abort

## Operation
- FSM: IDLE, SETUP, ACCESS. Reset state is IDLE.
- IDLE: request vector req[i] = PSEL_s[i].
  - If any request is present, select the winner, register its PADDR/PWRITE/PWDATA/PSTRB/PPROT into slave-side registers, set grant_id, and go to SETUP.
- Round-robin: search starts at pointer ptr and wraps modulo NUM_MASTERS. On grant of master k, ptr <= (k+1) mod NUM_MASTERS.
- Fixed priority: the lowest requesting index wins. ptr is unused and stays 0.
- SETUP: PSEL_m=1, PENABLE_m=0. Next state is always ACCESS.
- ACCESS: PSEL_m=1, PENABLE_m=1.
  - If PREADY_m=1, the transfer completes and the FSM returns to IDLE.
  - Otherwise the watchdog counter increments.
- Slave-side outputs come from registers and remain stable for the whole transfer, even if the master changes or drops its inputs (protocol violation). Such a transfer still completes normally.
- Response routing:
  - PRDATA_s[g] = PRDATA_m, PREADY_s[g] = PREADY_m, PSLVERR_s[g] = PSLVERR_m, only for g = grant_id and only in ACCESS.
  - All other masters, and all masters in IDLE and SETUP, see 0 on all three.
- Watchdog (TIMEOUT_CYCLES>0): counter is cleared on entry to ACCESS.
  - If ACCESS has lasted TIMEOUT_CYCLES cycles and PREADY_m=0, drive PREADY_s[g]=1, PSLVERR_s[g]=1, PRDATA_s[g]=0, pulse timeout_pulse, and go to IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Before reuse after an abort, the slave sees PSEL_m deassert for one or more cycles (IDLE).

## Timing
- Reset values:
  - All slave-side outputs 0; all PRDATA_s/PREADY_s/PSLVERR_s 0.
  - grant_id 0, busy 0, timeout_pulse 0, ptr 0, counter 0, state IDLE.
- Reset asserted mid-transfer aborts immediately: outputs go to reset values with no response to the master.
- Latency: PSEL_s[k] high in IDLE at cycle 0 → PSEL_m=1 at cycle 1 (SETUP) → PENABLE_m=1 at cycle 2.
  - The earliest PREADY_s[k] is at cycle 2, combinational from PREADY_m.
- Back-to-back: the completion cycle is followed by exactly one IDLE cycle in which arbitration runs. Minimum slave-side period is 3 cycles per transfer.
- PREADY_m=1 in the same cycle the watchdog expires: normal completion wins. PSLVERR_s follows PSLVERR_m and timeout_pulse stays 0.
- No requests while in IDLE: the FSM stays in IDLE and ptr holds.
- A master that loses arbitration sees PREADY_s=0 and keeps waiting, as APB requires.

## Test plan
- NUM_MASTERS=4, ARB_MODE=0, only master 2 writes 0xDEADBEEF to 0x100, PREADY_m high at first ACCESS:
  - PSEL_m at cycle 1, PENABLE_m at cycle 2.
  - PREADY_s[2]=1 at cycle 2, PWDATA_m=0xDEADBEEF.
  - Other PREADY_s stay 0.
- ARB_MODE=0, all four PSEL_s held continuously, zero-wait slave: grant order 0,1,2,3,0, a new SETUP every 3 cycles.
- ARB_MODE=1, masters 1 and 3 held continuously: master 1 always wins and master 3 is never granted.
- Read from master 0 with PRDATA_m=0x12345678, PSLVERR_m=1, 2 wait states:
  - PREADY_s[0]=1 at cycle 4 with PRDATA_s[0]=0x12345678 and PSLVERR_s[0]=1.
  - Other masters see all-zero responses.
- TIMEOUT_CYCLES=8, PREADY_m stuck 0:
  - After 8 ACCESS cycles, PREADY_s[g]=1, PSLVERR_s[g]=1, timeout_pulse=1 for one cycle.
  - PSEL_m=0 on the next cycle.
  - Repeat with PREADY_m rising on the expiry cycle: normal completion, no pulse.
- PRESETn asserted during ACCESS: PSEL_m, PENABLE_m, busy and all PREADY_s go 0 immediately. After release, the first grant is to master 0 (ptr=0).
